lpm_bipad_seq: RTL and testbench

LPM_BIPAD_SEQ -- requirements
Module: lpm_bipad_seq

---
 rtl/lpm_bipad_seq.sv | 147 ++++++++++++++
 tb/tb_lpm_bipad_seq.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpm_bipad_seq.sv
// lpm_bipad_seq
//   Sequences single-word transfers through a companion lpm_bipad tri-state pad.
//   A write drives the pad for lpm_hold cycles, pulses wr_done, then leaves the
//   bus released for lpm_turnaround cycles. A read leaves the pad undriven for
//   lpm_sample settle cycles, captures pad_result and pulses rsp_valid.
//
// Ports
//   clock       single clock, rising edge
//   sclr        synchronous active-high reset
//   cmd_valid   command presented
//   cmd_write   1 = write, 0 = read (sampled only at acceptance)
//   cmd_data    write word (sampled only at acceptance)
//   cmd_ready   command can be accepted this cycle (IDLE only)
//   wr_done     one-cycle pulse after a write's drive phase
//   rsp_valid   one-cycle pulse with a new read word on rsp_data
//   rsp_data    last captured read word
//   pad_data    to lpm_bipad data input, zero whenever not driving
//   pad_enable  to lpm_bipad enable input, 1 = drive
//   pad_result  from lpm_bipad result output
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a command, cmd_ready = 1
// WRITE | pad driven with the latched word for lpm_hold cycles
// TURN  | bus released after a write, lpm_turnaround cycles
// READ  | pad undriven, settling lpm_sample cycles before capture

module lpm_bipad_seq #(
    parameter int    lpm_width      = 1,
    parameter int    lpm_hold       = 1,
    parameter int    lpm_sample     = 1,
    parameter int    lpm_turnaround = 1,
    parameter string lpm_type       = "lpm_bipad_seq"
) (
    input  logic                 clock,
    input  logic                 sclr,
    input  logic                 cmd_valid,
    input  logic                 cmd_write,
    input  logic [lpm_width-1:0] cmd_data,
    output logic                 cmd_ready,
    output logic                 wr_done,
    output logic                 rsp_valid,
    output logic [lpm_width-1:0] rsp_data,
    output logic [lpm_width-1:0] pad_data,
    output logic                 pad_enable,
    input  logic [lpm_width-1:0] pad_result
);

    generate
        if (lpm_width <= 0 || lpm_hold < 1 || lpm_sample < 1 || lpm_turnaround < 0) begin : g_param_check
            $fatal(1, "%s: illegal parameter set (width>0, hold>=1, sample>=1, turnaround>=0)", lpm_type);
        end
    endgenerate

    localparam int max_hs    = (lpm_hold > lpm_sample) ? lpm_hold : lpm_sample;
    localparam int max_phase = (max_hs > lpm_turnaround) ? max_hs : lpm_turnaround;
    localparam int cnt_w     = (max_phase > 1) ? $clog2(max_phase + 1) : 1;

    // Counter is loaded with (phase length - 1) and the phase ends at zero.
    localparam logic [cnt_w-1:0] hold_load   = cnt_w'(lpm_hold - 1);
    localparam logic [cnt_w-1:0] sample_load = cnt_w'(lpm_sample - 1);
    localparam logic [cnt_w-1:0] turn_load   = cnt_w'((lpm_turnaround > 0) ? lpm_turnaround - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        TURN  = 2'd2,
        READ  = 2'd3
    } state_t;

    state_t           state;
    logic [cnt_w-1:0] cnt;

    always_ff @(posedge clock) begin
        wr_done   <= 1'b0;
        rsp_valid <= 1'b0;
        if (sclr) begin
            state      <= IDLE;
            cnt        <= '0;
            cmd_ready  <= 1'b1;
            pad_enable <= 1'b0;
            pad_data   <= '0;
            rsp_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (cmd_write) begin
                            state      <= WRITE;
                            cnt        <= hold_load;
                            pad_enable <= 1'b1;
                            pad_data   <= cmd_data;
                        end else begin
                            state <= READ;
                            cnt   <= sample_load;
                        end
                    end
                end
                WRITE: begin
                    if (cnt == '0) begin
                        wr_done    <= 1'b1;
                        pad_enable <= 1'b0;
                        pad_data   <= '0;
                        if (lpm_turnaround == 0) begin
                            state     <= IDLE;
                            cmd_ready <= 1'b1;
                        end else begin
                            state <= TURN;
                            cnt   <= turn_load;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                TURN: begin
                    if (cnt == '0) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                READ: begin
                    // Capture at the end of the last settle cycle; IDLE coincides
                    // with rsp_valid so another read can follow immediately.
                    if (cnt == '0) begin
                        rsp_data  <= pad_result;
                        rsp_valid <= 1'b1;
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    cmd_ready  <= 1'b1;
                    pad_enable <= 1'b0;
                    pad_data   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lpm_bipad_seq.sv
// tb_lpm_bipad_seq
//   Scoreboard bench for lpm_bipad_seq. Unit 0 uses width 8, hold 2, sample 3,
//   turnaround 1; unit 1 is the same but with zero turnaround. Stimulus pushes
//   expected per-cycle output snapshots and expected wr_done/rsp_valid pulses
//   into queues; a monitor pops and compares them as cycles and pulses occur.
//   Cycle b is the cycle whose closing edge accepts the command.

module tb_lpm_bipad_seq;

    logic       clk = 1'b0;
    logic       sclr;
    logic       cmd_valid0, cmd_write0, cmd_valid1, cmd_write1;
    logic [7:0] cmd_data0, cmd_data1, pad_result0, pad_result1;
    logic       cmd_ready0, wr_done0, rsp_valid0, pad_enable0;
    logic       cmd_ready1, wr_done1, rsp_valid1, pad_enable1;
    logic [7:0] rsp_data0, pad_data0, rsp_data1, pad_data1;

    always #5 clk = ~clk;

    lpm_bipad_seq #(.lpm_width(8), .lpm_hold(2), .lpm_sample(3), .lpm_turnaround(1)) dut (
        .clock(clk), .sclr(sclr), .cmd_valid(cmd_valid0), .cmd_write(cmd_write0),
        .cmd_data(cmd_data0), .cmd_ready(cmd_ready0), .wr_done(wr_done0),
        .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .pad_data(pad_data0),
        .pad_enable(pad_enable0), .pad_result(pad_result0));

    lpm_bipad_seq #(.lpm_width(8), .lpm_hold(2), .lpm_sample(3), .lpm_turnaround(0)) dut_t0 (
        .clock(clk), .sclr(sclr), .cmd_valid(cmd_valid1), .cmd_write(cmd_write1),
        .cmd_data(cmd_data1), .cmd_ready(cmd_ready1), .wr_done(wr_done1),
        .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .pad_data(pad_data1),
        .pad_enable(pad_enable1), .pad_result(pad_result1));

    // Snapshot layout: {cmd_ready, wr_done, rsp_valid, pad_enable, pad_data, rsp_data}
    localparam logic [19:0] M_RDY = 20'h80000;
    localparam logic [19:0] M_WD  = 20'h40000;
    localparam logic [19:0] M_RV  = 20'h20000;
    localparam logic [19:0] M_PE  = 20'h10000;
    localparam logic [19:0] M_PD  = 20'h0FF00;
    localparam logic [19:0] M_RD  = 20'h000FF;
    localparam logic [19:0] M_ALL = 20'hFFFFF;
    localparam logic [19:0] W     = M_RDY | M_WD | M_PE | M_PD;

    typedef struct {
        int          cyc;
        bit          unit;
        string       name;
        logic [19:0] val;
        logic [19:0] care;
    } exp_t;

    typedef struct {
        int         cyc;
        bit         unit;
        bit         kind;   // 0 = wr_done, 1 = rsp_valid
        logic [7:0] data;
    } ev_t;

    exp_t exp_q[$];
    ev_t  ev_q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    wire logic [19:0] out0 = {cmd_ready0, wr_done0, rsp_valid0, pad_enable0, pad_data0, rsp_data0};
    wire logic [19:0] out1 = {cmd_ready1, wr_done1, rsp_valid1, pad_enable1, pad_data1, rsp_data1};

    always @(posedge clk) cyc++;

    function automatic logic [19:0] drv(input logic [7:0] d);
        return M_PE | {4'h0, d, 8'h00};
    endfunction

    function automatic logic [19:0] rdw(input logic [7:0] d);
        return {12'h000, d};
    endfunction

    task automatic chk(input int c, input bit u, input string nm, input logic [19:0] v, input logic [19:0] m);
        exp_t e;
        e.cyc = c; e.unit = u; e.name = nm; e.val = v; e.care = m;
        exp_q.push_back(e);
    endtask

    task automatic ev(input int c, input bit u, input bit k, input logic [7:0] d);
        ev_t e;
        e.cyc = c; e.unit = u; e.kind = k; e.data = d;
        ev_q.push_back(e);
    endtask

    task automatic check_pulse(input bit u, input bit k, input logic p, input logic [7:0] d);
        ev_t e;
        if (p === 1'b1) begin
            n_tests++;
            if (ev_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse u%0d kind%0d cyc %0d: got pulse, want none", u, k, cyc);
            end else begin
                e = ev_q.pop_front();
                if (e.cyc != cyc || e.unit != u || e.kind != k || (k && d !== e.data)) begin
                    n_fail++;
                    $display("FAIL pulse u%0d kind%0d: got cyc %0d data %h, want u%0d kind%0d cyc %0d data %h",
                             u, k, cyc, d, e.unit, e.kind, e.cyc, e.data);
                end
            end
        end
    endtask

    // Monitor: samples 3 time units after each rising edge.
    always @(posedge clk) begin
        exp_t        e;
        ev_t         m;
        logic [19:0] obs;
        #3;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e   = exp_q.pop_front();
            obs = e.unit ? out1 : out0;
            n_tests++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s u%0d: check for cyc %0d reached at cyc %0d", e.name, e.unit, e.cyc, cyc);
            end else if (((obs ^ e.val) & e.care) !== 20'h0) begin
                n_fail++;
                $display("FAIL %s u%0d cyc %0d: got %h want %h (care %h)", e.name, e.unit, cyc, obs, e.val, e.care);
            end
        end
        while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
            m = ev_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missing_pulse u%0d kind%0d: got none at cyc %0d, want pulse", m.unit, m.kind, m.cyc);
        end
        check_pulse(1'b0, 1'b0, wr_done0, 8'h00);
        check_pulse(1'b0, 1'b1, rsp_valid0, rsp_data0);
        check_pulse(1'b1, 1'b0, wr_done1, 8'h00);
        check_pulse(1'b1, 1'b1, rsp_valid1, rsp_data1);
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) sync();
    endtask

    initial begin
        int b;
        sclr = 1'b1;
        cmd_valid0 = 1'b0; cmd_write0 = 1'b0; cmd_data0 = 8'h00; pad_result0 = 8'h00;
        cmd_valid1 = 1'b0; cmd_write1 = 1'b0; cmd_data1 = 8'h00; pad_result1 = 8'h00;

        // Reset state
        sync(); sync();
        b = cyc;
        chk(b + 1, 1'b0, "reset_u0", M_RDY, M_ALL);
        chk(b + 1, 1'b1, "reset_u1", M_RDY, M_ALL);
        sync();
        sclr = 1'b0;
        wait_until(b + 3);

        // Write 0xA5
        b = cyc;
        chk(b + 1, 1'b0, "wr_drive1", drv(8'hA5), W);
        chk(b + 2, 1'b0, "wr_drive2", drv(8'hA5), W);
        chk(b + 3, 1'b0, "wr_done", M_WD, W);
        chk(b + 4, 1'b0, "wr_ready", M_RDY, W);
        ev(b + 3, 1'b0, 1'b0, 8'h00);
        cmd_valid0 = 1'b1; cmd_write0 = 1'b1; cmd_data0 = 8'hA5;
        wait_until(b + 1);
        cmd_valid0 = 1'b0; cmd_data0 = 8'h00;
        wait_until(b + 5);

        // sclr beats an acceptance in the same cycle
        b = cyc;
        chk(b + 1, 1'b0, "sclr_prio", M_RDY, W);
        chk(b + 2, 1'b0, "sclr_prio_idle", M_RDY, W);
        cmd_valid0 = 1'b1; cmd_write0 = 1'b1; cmd_data0 = 8'h33; sclr = 1'b1;
        wait_until(b + 1);
        cmd_valid0 = 1'b0; cmd_data0 = 8'h00; sclr = 1'b0;
        wait_until(b + 4);

        // Read with pad_result 0x3C, then rsp_data holds while pad_result changes
        b = cyc;
        pad_result0 = 8'h3C;
        chk(b,     1'b0, "rd_accept", M_RDY, M_RDY | M_PE);
        chk(b + 1, 1'b0, "rd_settle1", 20'h0, M_RDY | M_PE | M_PD | M_RV);
        chk(b + 2, 1'b0, "rd_settle2", 20'h0, M_RDY | M_PE | M_PD | M_RV);
        chk(b + 3, 1'b0, "rd_settle3", 20'h0, M_RDY | M_PE | M_PD | M_RV);
        chk(b + 4, 1'b0, "rd_valid", M_RDY | M_RV | rdw(8'h3C), M_ALL);
        chk(b + 5, 1'b0, "rd_hold1", M_RDY | rdw(8'h3C), M_ALL);
        chk(b + 6, 1'b0, "rd_hold2", M_RDY | rdw(8'h3C), M_ALL);
        ev(b + 4, 1'b0, 1'b1, 8'h3C);
        cmd_valid0 = 1'b1; cmd_write0 = 1'b0;
        wait_until(b + 1);
        cmd_valid0 = 1'b0;
        wait_until(b + 4);
        pad_result0 = 8'h99;
        wait_until(b + 7);

        // Write 0x11 then a read held on cmd_valid from cycle 1
        b = cyc;
        pad_result0 = 8'h5A;
        chk(b + 1, 1'b0, "b2b_drive1", drv(8'h11), W);
        chk(b + 2, 1'b0, "b2b_drive2", drv(8'h11), W);
        chk(b + 3, 1'b0, "b2b_wr_done", M_WD, W);
        chk(b + 4, 1'b0, "b2b_ready", M_RDY, W);
        chk(b + 5, 1'b0, "b2b_read1", 20'h0, M_RDY | M_PE | M_PD | M_RV);
        chk(b + 6, 1'b0, "b2b_read2", 20'h0, M_RDY | M_PE | M_PD | M_RV);
        chk(b + 7, 1'b0, "b2b_read3", 20'h0, M_RDY | M_PE | M_PD | M_RV);
        chk(b + 8, 1'b0, "b2b_rsp", M_RDY | M_RV | rdw(8'h5A), M_ALL);
        ev(b + 3, 1'b0, 1'b0, 8'h00);
        ev(b + 8, 1'b0, 1'b1, 8'h5A);
        cmd_valid0 = 1'b1; cmd_write0 = 1'b1; cmd_data0 = 8'h11;
        wait_until(b + 1);
        cmd_write0 = 1'b0; cmd_data0 = 8'h00;
        wait_until(b + 5);
        cmd_valid0 = 1'b0;
        wait_until(b + 10);

        // sclr during a write aborts it, no wr_done, rsp_data cleared
        b = cyc;
        chk(b + 1, 1'b0, "rst_mid_drive", drv(8'h77), W);
        chk(b + 2, 1'b0, "rst_mid_idle", M_RDY, M_ALL);
        chk(b + 3, 1'b0, "rst_mid_after1", M_RDY, W);
        chk(b + 4, 1'b0, "rst_mid_after2", M_RDY, W);
        cmd_valid0 = 1'b1; cmd_write0 = 1'b1; cmd_data0 = 8'h77;
        wait_until(b + 1);
        cmd_valid0 = 1'b0; cmd_data0 = 8'h00; sclr = 1'b1;
        wait_until(b + 2);
        sclr = 1'b0;
        wait_until(b + 5);

        // Busy ignore: 0xFF write presented during cycles 1-3 of an 0xA5 write
        b = cyc;
        chk(b + 1, 1'b0, "busy_drive1", drv(8'hA5), W);
        chk(b + 2, 1'b0, "busy_drive2", drv(8'hA5), W);
        chk(b + 3, 1'b0, "busy_wr_done", M_WD, W);
        chk(b + 4, 1'b0, "busy_ready", M_RDY, W);
        chk(b + 5, 1'b0, "busy2_drive1", drv(8'hFF), W);
        chk(b + 6, 1'b0, "busy2_drive2", drv(8'hFF), W);
        chk(b + 7, 1'b0, "busy2_wr_done", M_WD, W);
        chk(b + 8, 1'b0, "busy2_ready", M_RDY, W);
        ev(b + 3, 1'b0, 1'b0, 8'h00);
        ev(b + 7, 1'b0, 1'b0, 8'h00);
        cmd_valid0 = 1'b1; cmd_write0 = 1'b1; cmd_data0 = 8'hA5;
        wait_until(b + 1);
        cmd_data0 = 8'hFF;
        wait_until(b + 5);
        cmd_valid0 = 1'b0; cmd_data0 = 8'h00;
        wait_until(b + 9);

        // Zero turnaround unit: wr_done and cmd_ready together
        b = cyc;
        chk(b + 1, 1'b1, "t0_drive1", drv(8'hC3), W);
        chk(b + 2, 1'b1, "t0_drive2", drv(8'hC3), W);
        chk(b + 3, 1'b1, "t0_done_ready", M_WD | M_RDY, W);
        chk(b + 4, 1'b1, "t0_idle", M_RDY, W);
        ev(b + 3, 1'b1, 1'b0, 8'h00);
        cmd_valid1 = 1'b1; cmd_write1 = 1'b1; cmd_data1 = 8'hC3;
        wait_until(b + 1);
        cmd_valid1 = 1'b0; cmd_data1 = 8'h00;
        wait_until(b + 6);

        sync();
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s u%0d: check for cyc %0d never reached", e.name, e.unit, e.cyc);
        end
        while (ev_q.size() > 0) begin
            ev_t m;
            m = ev_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missing_pulse u%0d kind%0d: got none, want pulse at cyc %0d", m.unit, m.kind, m.cyc);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
